armaria_io_hub: RTL

// Multi-channel, parametrised I/O handshake unit between the ARMAria control unit and board I/O.

---
 rtl/armaria_io_hub_pkg.sv | 17 +
 rtl/armaria_io_hub_rise_detect.sv | 24 ++
 rtl/armaria_io_hub.sv | 207 ++++++++++++++++++++
 3 files changed

// File: rtl/armaria_io_hub_pkg.sv
// Shared definitions for the ARMAria I/O hub: FSM state encodings and
// the channel-select width helper.
package armaria_io_hub_pkg;

    typedef logic [1:0] io_state_t;

    localparam logic [1:0] ST_IDLE      = 2'd0;
    localparam logic [1:0] ST_WAIT_IN   = 2'd1;
    localparam logic [1:0] ST_WAIT_CONT = 2'd2;
    localparam logic [1:0] ST_DONE      = 2'd3;

    // Channel select is never narrower than one bit, even for a single channel.
    function automatic int ch_width(input int channels);
        return (channels <= 2) ? 1 : $clog2(channels);
    endfunction

endpackage

// File: rtl/armaria_io_hub_rise_detect.sv
// Per-bit rising-edge detector: compares each level with its value one
// clock earlier, so a level that is already high never reports an edge.
module armaria_rise_detect #(
    parameter int WIDTH = 1
) (
    input  logic             clk,
    input  logic             srst,
    input  logic [WIDTH-1:0] level,
    output logic [WIDTH-1:0] rise
);

    logic [WIDTH-1:0] prev_reg;

    always_ff @(posedge clk) begin
        if (srst) begin
            prev_reg <= '0;
        end else begin
            prev_reg <= level;
        end
    end

    assign rise = level & ~prev_reg;

endmodule

// File: rtl/armaria_io_hub.sv
// Multi-channel I/O handshake unit: stalls the core via 'enable' while an
// input or output transaction on one of CHANNELS ports is in progress.
module armaria_io_hub
    import armaria_io_hub_pkg::*;
#(
    parameter int WORD_SIZE      = 32,
    parameter int IO_WIDTH       = 16,
    parameter int CHANNELS       = 4,
    parameter int FLAG_COUNT     = 5,
    parameter int HOLD_ON_OUTPUT = 0,
    localparam int CH_W          = ch_width(CHANNELS)
) (
    input  logic                         slow_clock,
    input  logic                         reset,
    input  logic                         is_input,
    input  logic                         is_output,
    input  logic [CH_W-1:0]              channel,
    input  logic [WORD_SIZE-1:0]         out_data,
    input  logic [CHANNELS*IO_WIDTH-1:0] in_bus,
    input  logic [CHANNELS-1:0]          in_valid,
    input  logic                         continue_in,
    input  logic                         os_request,
    input  logic [3:0]                   flags,
    input  logic                         is_os,
    output logic                         enable,
    output logic [WORD_SIZE-1:0]         in_word,
    output logic [CHANNELS*IO_WIDTH-1:0] out_bus,
    output logic [CHANNELS-1:0]          out_strobe,
    output logic [FLAG_COUNT-1:0]        gled,
    output logic                         irq_pending,
    output logic                         io_error
);

    io_state_t                   state_reg, state_next;
    logic [CH_W-1:0]             ch_q_reg, ch_q_next;
    logic [WORD_SIZE-1:0]        in_word_reg;
    logic [CHANNELS*IO_WIDTH-1:0] out_bus_reg;
    logic [CHANNELS-1:0]         out_strobe_reg;
    logic [FLAG_COUNT-1:0]       gled_reg;
    logic                        irq_pending_reg, irq_pending_next;
    logic                        io_error_reg;

    logic [CHANNELS-1:0]         valid_rise;
    logic                        cont_rise;
    logic                        os_rise;

    armaria_rise_detect #(.WIDTH(CHANNELS)) u_valid_rise (
        .clk   (slow_clock),
        .srst  (reset),
        .level (in_valid),
        .rise  (valid_rise)
    );

    armaria_rise_detect #(.WIDTH(1)) u_cont_rise (
        .clk   (slow_clock),
        .srst  (reset),
        .level (continue_in),
        .rise  (cont_rise)
    );

    armaria_rise_detect #(.WIDTH(1)) u_os_rise (
        .clk   (slow_clock),
        .srst  (reset),
        .level (os_request),
        .rise  (os_rise)
    );

    logic [IO_WIDTH-1:0] in_slice [CHANNELS];
    logic [CHANNELS-1:0] channel_hit;
    logic [CHANNELS-1:0] out_write;
    logic                write_out;

    // Decoding by equality keeps out-of-range selects harmless for any CHANNELS.
    generate
        for (genvar gi = 0; gi < CHANNELS; gi++) begin : g_chan
            assign in_slice[gi]    = in_bus[gi*IO_WIDTH +: IO_WIDTH];
            assign channel_hit[gi] = (channel == CH_W'(gi));
            assign out_write[gi]   = write_out & channel_hit[gi];
        end
        if (WORD_SIZE > IO_WIDTH) begin : g_unused_hi
            logic unused_out_hi;
            assign unused_out_hi = ^out_data[WORD_SIZE-1:IO_WIDTH];
        end
    endgenerate

    logic [IO_WIDTH-1:0] sel_slice;
    logic                sel_rise;

    always_comb begin
        sel_slice = '0;
        sel_rise  = 1'b0;
        for (int k = 0; k < CHANNELS; k++) begin
            if (ch_q_reg == CH_W'(k)) begin
                sel_slice = in_slice[k];
                sel_rise  = valid_rise[k];
            end
        end
    end

    logic req;
    logic req_both;
    logic chan_ok;
    logic irq_rise;
    logic capture;
    logic flag_error;

    assign req      = is_input ^ is_output;
    assign req_both = is_input & is_output;
    assign chan_ok  = |channel_hit;

    // A new OS request wins over a same-cycle clear by is_os.
    assign irq_pending_next = os_rise | (irq_pending_reg & ~is_os);
    assign irq_rise         = irq_pending_next & ~irq_pending_reg;

    always_comb begin
        state_next = state_reg;
        ch_q_next  = ch_q_reg;
        capture    = 1'b0;
        write_out  = 1'b0;
        flag_error = 1'b0;
        case (state_reg)
            ST_IDLE: begin
                if (req_both) begin
                    flag_error = 1'b1;
                    state_next = ST_DONE;
                end else if (req) begin
                    if (!chan_ok) begin
                        flag_error = 1'b1;
                        state_next = ST_DONE;
                    end else if (is_input) begin
                        ch_q_next  = channel;
                        state_next = ST_WAIT_IN;
                    end else begin
                        write_out  = 1'b1;
                        state_next = (HOLD_ON_OUTPUT != 0) ? ST_WAIT_CONT : ST_DONE;
                    end
                end
            end
            ST_WAIT_IN: begin
                // An OS request aborts the wait without capturing anything.
                if (irq_rise) begin
                    state_next = ST_DONE;
                end else if (sel_rise) begin
                    capture    = 1'b1;
                    state_next = ST_DONE;
                end
            end
            ST_WAIT_CONT: begin
                if (irq_rise || cont_rise) begin
                    state_next = ST_DONE;
                end
            end
            ST_DONE: begin
                state_next = ST_IDLE;
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge slow_clock) begin
        if (reset) begin
            state_reg       <= ST_IDLE;
            ch_q_reg        <= '0;
            in_word_reg     <= '0;
            gled_reg        <= '0;
            irq_pending_reg <= 1'b0;
            io_error_reg    <= 1'b0;
        end else begin
            state_reg       <= state_next;
            ch_q_reg        <= ch_q_next;
            irq_pending_reg <= irq_pending_next;
            gled_reg        <= FLAG_COUNT'({is_os, flags});
            if (capture) begin
                in_word_reg <= WORD_SIZE'(sel_slice);
            end
            if (flag_error) begin
                io_error_reg <= 1'b1;
            end
        end
    end

    always_ff @(posedge slow_clock) begin
        if (reset) begin
            out_bus_reg    <= '0;
            out_strobe_reg <= '0;
        end else begin
            out_strobe_reg <= out_write;
            for (int k = 0; k < CHANNELS; k++) begin
                if (out_write[k]) begin
                    out_bus_reg[k*IO_WIDTH +: IO_WIDTH] <= out_data[IO_WIDTH-1:0];
                end
            end
        end
    end

    // Mealy release: the core may run through idle cycles with no request.
    assign enable      = !reset && (((state_reg == ST_IDLE) && !req) || (state_reg == ST_DONE));
    assign in_word     = in_word_reg;
    assign out_bus     = out_bus_reg;
    assign out_strobe  = out_strobe_reg;
    assign gled        = gled_reg;
    assign irq_pending = irq_pending_reg;
    assign io_error    = io_error_reg;

endmodule
